// File: rtl/branch_resolver_if.sv
// Bundle between the fetch/execute pipeline and the branch resolver:
// prediction push channel, in-order resolve channel and predictor-training outputs.
interface branch_resolver_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic              push_valid;
    logic [ADDR_W-1:0] push_pc;
    logic              push_taken;
    logic [ADDR_W-1:0] push_target;
    logic              push_ready;

    logic              res_valid;
    logic              res_taken;
    logic [ADDR_W-1:0] res_target;

    logic              update_predict;
    logic              predict_success;
    logic [ADDR_W-1:0] last_branch_pc;
    logic              flush;
    logic [ADDR_W-1:0] redirect_pc;
    logic [OCC_W-1:0]  occupancy;
    logic              resolve_err;
    logic [CNT_W-1:0]  mispredict_cnt;

    modport master (
        output push_valid, push_pc, push_taken, push_target,
        output res_valid, res_taken, res_target,
        input  push_ready, update_predict, predict_success, last_branch_pc,
        input  flush, redirect_pc, occupancy, resolve_err, mispredict_cnt
    );

    modport slave (
        input  push_valid, push_pc, push_taken, push_target,
        input  res_valid, res_taken, res_target,
        output push_ready, update_predict, predict_success, last_branch_pc,
        output flush, redirect_pc, occupancy, resolve_err, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolver.sv
// Holds in-flight branch predictions in a circular FIFO and checks them against
// in-order EX resolutions, producing predictor training pulses and mispredict flushes.
module branch_resolver #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input logic             clk,
    input logic             rst,
    branch_resolver_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] pcMem_q     [DEPTH];
    logic              takenMem_q  [DEPTH];
    logic [ADDR_W-1:0] targetMem_q [DEPTH];

    logic [PTR_W:0]    wrPtr_q, wrPtr_d;
    logic [PTR_W:0]    rdPtr_q, rdPtr_d;
    logic              updatePredict_q, updatePredict_d;
    logic              predictSuccess_q, predictSuccess_d;
    logic [ADDR_W-1:0] lastBranchPc_q, lastBranchPc_d;
    logic              flush_q, flush_d;
    logic [ADDR_W-1:0] redirectPc_q, redirectPc_d;
    logic              resolveErr_q, resolveErr_d;
    logic [CNT_W-1:0]  mispredictCnt_q, mispredictCnt_d;

    logic [PTR_W:0]    occ;
    logic              full;
    logic              empty;
    logic [PTR_W-1:0]  rdIdx;
    logic [PTR_W-1:0]  wrIdx;
    logic [ADDR_W-1:0] headPc;
    logic              headTaken;
    logic [ADDR_W-1:0] headTarget;
    logic              resHit;
    logic              dirMatch;
    logic              mispredict;
    logic              pushOk;

    // The extra wrap bit on each pointer disambiguates full from empty.
    assign occ   = wrPtr_q - rdPtr_q;
    assign full  = (occ == FULL_OCC);
    assign empty = (occ == '0);
    assign rdIdx = rdPtr_q[PTR_W-1:0];
    assign wrIdx = wrPtr_q[PTR_W-1:0];

    assign headPc     = pcMem_q[rdIdx];
    assign headTaken  = takenMem_q[rdIdx];
    assign headTarget = targetMem_q[rdIdx];

    assign resHit     = bus.res_valid && !empty;
    assign dirMatch   = (bus.res_taken == headTaken);
    assign mispredict = resHit &&
                        (!dirMatch || (bus.res_taken && headTaken && (bus.res_target != headTarget)));

    // A correct pop frees the head slot, so a push may still land while full.
    assign pushOk = bus.push_valid && !flush_q && !mispredict && (!full || resHit);

    always_comb begin
        wrPtr_d          = wrPtr_q;
        rdPtr_d          = rdPtr_q;
        updatePredict_d  = resHit;
        predictSuccess_d = resHit && dirMatch;
        lastBranchPc_d   = lastBranchPc_q;
        flush_d          = mispredict;
        redirectPc_d     = redirectPc_q;
        resolveErr_d     = resolveErr_q || (bus.res_valid && empty);
        mispredictCnt_d  = mispredictCnt_q;

        if (resHit) begin
            lastBranchPc_d = headPc;
        end

        if (mispredict) begin
            rdPtr_d      = wrPtr_q;
            redirectPc_d = bus.res_taken ? bus.res_target : headPc + ADDR_W'(4);
            if (mispredictCnt_q != '1) begin
                mispredictCnt_d = mispredictCnt_q + CNT_W'(1);
            end
        end else begin
            rdPtr_d = rdPtr_q + (PTR_W + 1)'(resHit);
            wrPtr_d = wrPtr_q + (PTR_W + 1)'(pushOk);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q          <= '0;
            rdPtr_q          <= '0;
            updatePredict_q  <= 1'b0;
            predictSuccess_q <= 1'b0;
            lastBranchPc_q   <= '0;
            flush_q          <= 1'b0;
            redirectPc_q     <= '0;
            resolveErr_q     <= 1'b0;
            mispredictCnt_q  <= '0;
        end else begin
            wrPtr_q          <= wrPtr_d;
            rdPtr_q          <= rdPtr_d;
            updatePredict_q  <= updatePredict_d;
            predictSuccess_q <= predictSuccess_d;
            lastBranchPc_q   <= lastBranchPc_d;
            flush_q          <= flush_d;
            redirectPc_q     <= redirectPc_d;
            resolveErr_q     <= resolveErr_d;
            mispredictCnt_q  <= mispredictCnt_d;
        end
    end

    // Entry storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && pushOk) begin
            pcMem_q[wrIdx]     <= bus.push_pc;
            takenMem_q[wrIdx]  <= bus.push_taken;
            targetMem_q[wrIdx] <= bus.push_target;
        end
    end

    assign bus.push_ready      = !full && !flush_q;
    assign bus.update_predict  = updatePredict_q;
    assign bus.predict_success = predictSuccess_q;
    assign bus.last_branch_pc  = lastBranchPc_q;
    assign bus.flush           = flush_q;
    assign bus.redirect_pc     = redirectPc_q;
    assign bus.occupancy       = occ;
    assign bus.resolve_err     = resolveErr_q;
    assign bus.mispredict_cnt  = mispredictCnt_q;
endmodule
